// File: rtl/d16_cptn.sv
// Parametrised up/down counter with runtime step/limit, wrap or saturate, tc pulse and sticky ovf.
// Optional compare unit compiled in with D16_CPTN_CMP_EN.
module d16_cptn #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic              clr,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat,
  input  logic              ovf_clr,
`ifdef D16_CPTN_CMP_EN
  input  logic [WIDTH-1:0]  cmp_val,
  output logic              cmp_match,
`endif
  output logic [WIDTH-1:0]  dout,
  output logic              tc,
  output logic              ovf
);

  // Arithmetic width wide enough for both operands plus a carry bit.
  localparam int unsigned CW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tc_q, ovf_q, ovf_d;
  logic             evt;

  logic [CW-1:0]    cnt_x, step_x, lim_x, sum_x;
  logic [WIDTH-1:0] diff_w;

  assign cnt_x  = CW'(dout_q);
  assign step_x = CW'(step);
  assign lim_x  = CW'(limit);
  assign sum_x  = cnt_x + step_x;
  // Only used when step <= dout, so truncating step is safe there.
  assign diff_w = dout_q - WIDTH'(step);

  always_comb begin
    dout_d = dout_q;
    evt    = 1'b0;
    if (clr) begin
      dout_d = '0;
    end else if (load) begin
      dout_d = (din > limit) ? limit : din;
    end else if (en && (step != '0)) begin
      if (dir) begin
        if (sum_x > lim_x) begin
          evt    = 1'b1;
          dout_d = sat ? limit : '0;
        end else begin
          dout_d = sum_x[WIDTH-1:0];
        end
      end else begin
        if (step_x > cnt_x) begin
          evt    = 1'b1;
          dout_d = sat ? '0 : limit;
        end else begin
          dout_d = diff_w;
        end
      end
    end
  end

  // Set wins over a simultaneous clear.
  assign ovf_d = evt | (ovf_q & ~ovf_clr);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      dout_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      tc_q   <= evt;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

`ifdef D16_CPTN_CMP_EN
  logic cmp_q;

  // Compared against the next count so the flag lines up with dout.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= (dout_d == cmp_val);
    end
  end

  assign cmp_match = cmp_q;
`endif

endmodule

// File: tb/tb_d16_cptn.sv
// Directed self-checking bench for d16_cptn (default WIDTH=16, STEP_W=4).
module tb_d16_cptn;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en, dir, load, clr, sat, ovf_clr;
  logic [15:0] din, limit;
  logic [3:0]  step;
  logic [15:0] dout;
  logic        tc, ovf;
`ifdef D16_CPTN_CMP_EN
  logic [15:0] cmp_val;
  logic        cmp_match;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  d16_cptn #(.WIDTH(16), .STEP_W(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .din      (din),
    .clr      (clr),
    .step     (step),
    .limit    (limit),
    .sat      (sat),
    .ovf_clr  (ovf_clr),
`ifdef D16_CPTN_CMP_EN
    .cmp_val  (cmp_val),
    .cmp_match(cmp_match),
`endif
    .dout     (dout),
    .tc       (tc),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [15:0] d, input logic t, input logic o);
    check({tag, ".dout"}, 32'(dout), 32'(d));
    check({tag, ".tc"},   32'(tc),   32'(t));
    check({tag, ".ovf"},  32'(ovf),  32'(o));
  endtask

  initial begin
    logic [15:0] wrap_seq [5];
    logic [15:0] sat_seq  [4];
    logic        sat_tc   [4];
    wrap_seq = '{16'd3, 16'd6, 16'd9, 16'd0, 16'd3};
    sat_seq  = '{16'd3, 16'd1, 16'd0, 16'd0};
    sat_tc   = '{1'b0, 1'b0, 1'b1, 1'b1};

    sys_rst = 1'b0;
    en = 1'b1; dir = 1'b1; load = 1'b0; clr = 1'b0; sat = 1'b0; ovf_clr = 1'b0;
    din = '0; limit = 16'hffff; step = 4'd1;
`ifdef D16_CPTN_CMP_EN
    cmp_val = 16'd7;
`endif

    // Reset held with en=1
    #2;
    expect3("rst_t0", 16'd0, 1'b0, 1'b0);
    repeat (3) tick();
    expect3("rst_held", 16'd0, 1'b0, 1'b0);
`ifdef D16_CPTN_CMP_EN
    check("rst_cmp", 32'(cmp_match), 32'd0);
`endif
    sys_rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect3($sformatf("count%0d", i), 16'(i), 1'b0, 1'b0);
    end

    // Clear, then wrap up with limit 9, step 3
    clr = 1'b1;
    tick();
    expect3("clr", 16'd0, 1'b0, 1'b0);
    clr = 1'b0; limit = 16'd9; step = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect3($sformatf("wrap%0d", i), wrap_seq[i], (i == 3), (i >= 3));
    end
    en = 1'b0; ovf_clr = 1'b1;
    tick();
    expect3("ovf_clr", 16'd3, 1'b0, 1'b0);
    ovf_clr = 1'b0;

    // Saturating down count from loaded 5, step 2
    sat = 1'b1; dir = 1'b0; load = 1'b1; din = 16'd5; step = 4'd2; en = 1'b1;
    tick();
    expect3("sat_load", 16'd5, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect3($sformatf("sat%0d", i), sat_seq[i], sat_tc[i], (i >= 2));
    end

    // Load clamps to limit; clr beats load
    en = 1'b0; load = 1'b1; din = 16'hcaca; limit = 16'h1000;
    tick();
    expect3("load_clamp", 16'h1000, 1'b0, 1'b1);
    clr = 1'b1;
    tick();
    expect3("clr_over_load", 16'h0000, 1'b0, 1'b1);
    clr = 1'b0; load = 1'b0; ovf_clr = 1'b1;
    tick();
    expect3("ovf_clr2", 16'h0000, 1'b0, 1'b0);
    // Underflow wrap while ovf_clr asserted: set wins
    sat = 1'b0; en = 1'b1; step = 4'd1;
    tick();
    expect3("set_wins", 16'h1000, 1'b1, 1'b1);
    ovf_clr = 1'b0;

    // Hold: en=0, then step=0
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("hold_en.dout", 32'(dout), 32'h1000);
      check("hold_en.tc", 32'(tc), 32'd0);
    end
    en = 1'b1; step = 4'd0; dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_step.dout", 32'(dout), 32'h1000);
      check("hold_step.tc", 32'(tc), 32'd0);
    end

    // Limit lowered below count: next up step is an event
    step = 4'd1; limit = 16'h0010;
    tick();
    expect3("lim_low", 16'h0000, 1'b1, 1'b1);

    // Async reset mid-cycle discards tc/ovf
    #2 sys_rst = 1'b0;
    #1;
    expect3("async_rst", 16'h0000, 1'b0, 1'b0);
    tick();
    sys_rst = 1'b1;
    tick();
    expect3("post_rst", 16'h0001, 1'b0, 1'b0);

`ifdef D16_CPTN_CMP_EN
    clr = 1'b1; limit = 16'hffff;
    tick();
    check("cmp_clr", 32'(cmp_match), 32'd0);
    clr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("cmp_cnt%0d", i), 32'(cmp_match), 32'(i == 7));
    end
    load = 1'b1; din = 16'd7; en = 1'b0;
    tick();
    check("cmp_load", 32'(cmp_match), 32'd1);
    load = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
